// File: rtl/ef_adc_pkg.sv
// Shared ADC constants and sample type.
// Used by the ADC controller, its bus wrapper and the averaging stage.
package ef_adc_pkg;
    localparam int DW       = 8;
    localparam int MAX_LOG2 = 7;
    localparam int CHW      = 3;
    localparam int LOGW     = 3;
    localparam int ACCW     = DW + MAX_LOG2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [CHW-1:0] ch;
    } adc_sample_t;

    // Oversampling exponents above MAX_LOG2 are clamped to MAX_LOG2.
    function automatic logic [LOGW-1:0] sat_log2(input logic [LOGW-1:0] l);
        return (int'(l) > MAX_LOG2) ? LOGW'(MAX_LOG2) : l;
    endfunction
endpackage

// File: rtl/ef_adc_avg_acc_bank.sv
// Per-channel accumulator/counter register file with one read-modify-write port.
// done/result are combinational in the cycle of the completing sample.
module ef_adc_avg_acc_bank
    import ef_adc_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_vld,
    input  adc_sample_t      i_smp,
    input  logic [LOGW-1:0]  i_log2,
    output logic             o_done,
    output logic [DW-1:0]    o_result,
    output logic [CHW-1:0]   o_ch
);
    logic [NCH-1:0][ACCW-1:0]     r_acc;
    logic [NCH-1:0][MAX_LOG2-1:0] r_cnt;

    logic                w_ch_ok;
    logic                w_hit;
    logic [ACCW-1:0]     w_sum;
    logic [MAX_LOG2:0]   w_n;
    logic [MAX_LOG2-1:0] w_nm1;

    generate
        if (NCH >= (1 << CHW)) begin : g_full_tag
            assign w_ch_ok = 1'b1;
        end else begin : g_part_tag
            assign w_ch_ok = (32'(i_smp.ch) < NCH);
        end
    endgenerate

    assign w_hit    = i_vld & w_ch_ok;
    assign w_sum    = r_acc[i_smp.ch] + ACCW'(i_smp.data);
    assign w_n      = (MAX_LOG2+1)'(1) << i_log2;
    assign w_nm1    = MAX_LOG2'(w_n - 1'b1);
    // ">=" lets a counter left high by an exponent change finish on its next sample.
    assign o_done   = w_hit & (r_cnt[i_smp.ch] >= w_nm1);
    assign o_result = DW'(w_sum >> i_log2);
    assign o_ch     = i_smp.ch;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!i_en || i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_hit) begin
            if (o_done) begin
                r_acc[i_smp.ch] <= '0;
                r_cnt[i_smp.ch] <= '0;
            end else begin
                r_acc[i_smp.ch] <= w_sum;
                r_cnt[i_smp.ch] <= r_cnt[i_smp.ch] + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ef_adc_avg_win.sv
// ADC oversampling averager with a single-entry output holding register,
// valid/ready drain and window-comparator event pulses.
module ef_adc_avg_win
    import ef_adc_pkg::*;
#(
    parameter int NCH = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             en,
    input  logic             clr,
    input  logic [LOGW-1:0]  avg_log2,
    input  logic [DW-1:0]    low_th,
    input  logic [DW-1:0]    high_th,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    input  logic [CHW-1:0]   s_ch,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CHW-1:0]   m_ch,
    output logic             below,
    output logic             above,
    output logic             ovf
);
    adc_sample_t     w_smp;
    logic            w_vld;
    logic            w_done;
    logic [DW-1:0]   w_result;
    logic [CHW-1:0]  w_res_ch;
    logic            w_full;

    logic            r_m_valid;
    logic [DW-1:0]   r_m_data;
    logic [CHW-1:0]  r_m_ch;
    logic            r_below;
    logic            r_above;
    logic            r_ovf;

    assign w_smp.data = s_data;
    assign w_smp.ch   = s_ch;
    assign w_vld      = s_valid & en & ~clr;
    assign w_full     = r_m_valid & ~m_ready;

    ef_adc_avg_acc_bank #(.NCH(NCH)) u_bank (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .i_en     (en),
        .i_clr    (clr),
        .i_vld    (w_vld),
        .i_smp    (w_smp),
        .i_log2   (sat_log2(avg_log2)),
        .o_done   (w_done),
        .o_result (w_result),
        .o_ch     (w_res_ch)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ch    <= '0;
            r_below   <= 1'b0;
            r_above   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_below <= 1'b0;
            r_above <= 1'b0;
            r_ovf   <= 1'b0;
            if (w_done && w_full) begin
                // Holding register busy: the new result is lost, only ovf reports it.
                r_ovf <= 1'b1;
            end else if (w_done) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_result;
                r_m_ch    <= w_res_ch;
                r_below   <= (w_result < low_th);
                r_above   <= (w_result > high_th);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_ch    = r_m_ch;
    assign below   = r_below;
    assign above   = r_above;
    assign ovf     = r_ovf;
endmodule

// File: tb/tb_ef_adc_avg_win.sv
// Bench for ef_adc_avg_win: vector table, corner sequences, then random
// traffic checked against a sample-list averaging model.
module tb_ef_adc_avg_win;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       en = 1'b1, clr = 1'b0;
    logic [2:0] avg_log2 = '0;
    logic [7:0] low_th = '0, high_th = 8'hFF;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic [2:0] s_ch = '0;
    logic       m_valid, m_ready = 1'b1;
    logic [7:0] m_data;
    logic [2:0] m_ch;
    logic       below, above, ovf;

    int n_chk = 0, n_fail = 0;

    ef_adc_avg_win dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .clr(clr), .avg_log2(avg_log2),
        .low_th(low_th), .high_th(high_th), .s_valid(s_valid), .s_data(s_data),
        .s_ch(s_ch), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_ch(m_ch), .below(below), .above(above), .ovf(ovf)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic samp(input logic [2:0] ch, input logic [7:0] d);
        s_valid = 1'b1; s_ch = ch; s_data = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic v, input int d, input int c,
                           input logic b, input logic a, input logic o);
        chk({nm, ".valid"}, m_valid, v);
        if (v) begin
            chk({nm, ".data"}, m_data, d);
            chk({nm, ".ch"}, m_ch, c);
        end
        chk({nm, ".below"}, below, b);
        chk({nm, ".above"}, above, a);
        chk({nm, ".ovf"}, ovf, o);
    endtask

    typedef struct {
        logic       sv;
        logic [2:0] lg;
        logic [7:0] lo, hi;
        logic [2:0] ch;
        logic [7:0] d;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       eb, ea, eo;
    } vec_t;
    vec_t vq[$];

    // Random-phase reference: per-channel list of accepted samples.
    int   mq[8][$];
    logic pv;
    int   pd, pc;

    initial begin
        // sv lg lo hi ch d rdy | ev ed ec eb ea eo
        vq.push_back('{1, 2, 0, 255, 3, 10, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 2, 0, 255, 3, 11, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 2, 0, 255, 3, 12, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 2, 0, 255, 3, 13, 1, 1, 11, 3, 0, 0, 0});
        vq.push_back('{1, 0, 50, 100, 0, 40, 1, 1, 40, 0, 1, 0, 0});
        vq.push_back('{1, 0, 50, 100, 0, 120, 1, 1, 120, 0, 0, 1, 0});
        vq.push_back('{1, 1, 0, 255, 1, 200, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 1, 0, 255, 2, 4, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 1, 0, 255, 1, 202, 1, 1, 201, 1, 0, 0, 0});
        vq.push_back('{1, 1, 0, 255, 2, 6, 1, 1, 5, 2, 0, 0, 0});
        vq.push_back('{0, 1, 0, 255, 0, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 0, 100, 100, 4, 100, 1, 1, 100, 4, 0, 0, 0});
        vq.push_back('{1, 0, 200, 10, 6, 50, 1, 1, 50, 6, 1, 1, 0});

        #2;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        tick(); tick();
        HRESETn = 1'b1;
        tick();

        foreach (vq[i]) begin
            s_valid = vq[i].sv; avg_log2 = vq[i].lg; low_th = vq[i].lo;
            high_th = vq[i].hi; s_ch = vq[i].ch; s_data = vq[i].d; m_ready = vq[i].rdy;
            tick();
            chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].ec,
                    vq[i].eb, vq[i].ea, vq[i].eo);
        end
        s_valid = 1'b0; low_th = 0; high_th = 255;
        tick();

        // Holding register full: second result dropped, ovf once.
        m_ready = 1'b0; avg_log2 = 0;
        samp(0, 7);  chk_out("ovf.first", 1, 7, 0, 0, 0, 0);
        samp(0, 9);  chk_out("ovf.drop", 1, 7, 0, 0, 0, 1);
        tick();      chk_out("ovf.hold", 1, 7, 0, 0, 0, 0);
        m_ready = 1'b1;
        tick();      chk_out("ovf.drain", 0, 0, 0, 0, 0, 0);

        // Full 128-sample window, then clr mid-run.
        avg_log2 = 7;
        for (int i = 0; i < 128; i++) begin
            samp(5, 255);
            if (i == 126) chk("w128.early", m_valid, 0);
        end
        chk_out("w128.max", 1, 255, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) samp(5, 200);
        clr = 1'b1; samp(5, 200); clr = 1'b0;
        for (int i = 0; i < 128; i++) begin
            samp(5, 1);
            if (i == 126) chk("w128.clr_early", m_valid, 0);
        end
        chk_out("w128.after_clr", 1, 1, 5, 0, 0, 0);
        tick();

        // Asynchronous reset mid-accumulation with a pending result.
        m_ready = 1'b0; avg_log2 = 0;
        samp(0, 33);
        chk("rst.pending", m_valid, 1);
        avg_log2 = 2; m_ready = 1'b1;
        samp(1, 8); samp(1, 8);
        #2 HRESETn = 1'b0;
        #1 chk_out("rst.async", 0, 0, 0, 0, 0, 0);
        chk("rst.data", m_data, 0);
        tick();
        HRESETn = 1'b1;
        samp(1, 8); samp(1, 8); samp(1, 8);
        chk("rst.no_stale", m_valid, 0);
        samp(1, 8);
        chk_out("rst.fresh", 1, 8, 1, 0, 0, 0);

        // Random traffic against the model.
        m_ready = 1'b1; clr = 1'b1; tick(); clr = 1'b0; tick();
        pv = 0;
        for (int c = 0; c < 8; c++) mq[c].delete();
        for (int seg = 0; seg < 6; seg++) begin
            avg_log2 = 3'($urandom_range(0, 3));
            low_th = 8'($urandom_range(0, 255));
            high_th = 8'($urandom_range(0, 255));
            clr = 1'b1; s_valid = 1'b0; tick(); clr = 1'b0;
            for (int c = 0; c < 8; c++) mq[c].delete();
            if (m_ready) pv = 0;
            for (int cyc = 0; cyc < 150; cyc++) begin
                int  n, sum, res;
                logic done, eb, ea, eo;
                s_valid = ($urandom_range(0, 3) != 0);
                s_ch = 3'($urandom_range(0, 7));
                s_data = 8'($urandom_range(0, 255));
                m_ready = ($urandom_range(0, 2) != 0);
                en = ($urandom_range(0, 19) != 0);
                clr = ($urandom_range(0, 49) == 0);
                n = 1 << avg_log2;
                done = 0; eb = 0; ea = 0; eo = 0; res = 0;
                if (s_valid && en && !clr) begin
                    mq[s_ch].push_back(s_data);
                    if (mq[s_ch].size() == n) begin
                        sum = 0;
                        foreach (mq[s_ch][k]) sum += mq[s_ch][k];
                        res = sum / n;
                        done = 1;
                        mq[s_ch].delete();
                    end
                end
                if (!en || clr) for (int c = 0; c < 8; c++) mq[c].delete();
                if (done && pv && !m_ready) eo = 1;
                else if (done) begin
                    pv = 1; pd = res; pc = s_ch;
                    eb = (res < low_th); ea = (res > high_th);
                end else if (m_ready) pv = 0;
                tick();
                chk_out($sformatf("rnd%0d.%0d", seg, cyc), pv, pd, pc, eb, ea, eo);
            end
            s_valid = 1'b0; en = 1'b1; clr = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
